fp21_unpack_arbiter: RTL and testbench
======================================

// Module: fp21_unpack_arbiter
// PURPOSE
//   Shares one registered FP21 unpack stage among NREQ requesters using round-robin arbitration.
//   Each requester presents a packed FP21 word with a valid/ready handshake.
//   The winning word is unpacked into sign, unbiased exponent and fraction with the hidden bit
//   (denormals handled), plus class flags and the source index. The result is held in a single
//   output register with a valid/ready handshake toward the downstream FP21 arithmetic cores.
// PARAMETERS
//   NREQ    4    number of requesters, >=2
//   EXP_W   8    FP21 exponent field width
//   FRAC_W  12   FP21 stored fraction width; word width W = 1+EXP_W+FRAC_W = 21
//   BIAS    127  exponent bias
// PORTS
//   clk        in   1             clock, all state updates on rising edge
//   rst        in   1             synchronous reset, active-high
//   req_valid  in   NREQ          requester i has a word
//   req_data   in   NREQ*W        word i at bits [i*W +: W]
//   req_ready  out  NREQ          one-hot or zero; bit i = word i consumed this cycle
//   out_valid  out  1             result register holds a valid result
//   out_ready  in   1             downstream accepts the result
//   out_sign   out  1             sign bit
//   out_exp    out  EXP_W+1       unbiased exponent, two's complement
//   out_frac   out  FRAC_W+1      {hidden bit, stored fraction}
//   out_src    out  clog2(NREQ)   index of the winning requester
//   out_zero / out_denorm / out_inf / out_nan   out  1 each   class flags
// BEHAVIOUR
//   - Reset values: out_valid=0; all out_* data and flags=0; rr_ptr=0.
//     req_ready is combinational and is 0 while rst=1.
//   - can_load = !out_valid || out_ready.
//   - Grant: if can_load, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ...
//     with wrap at NREQ-1 -> 0. req_ready = onehot(grant). No grant if can_load=0 or no valid.
//   - req_ready[i] never depends on req_data. It depends only on req_valid, rr_ptr, out_valid
//     and out_ready.
//   - On grant to i: at the next edge the result register loads the unpacked word i,
//     out_src=i and out_valid=1. rr_ptr becomes (i+1) mod NREQ.
//     Latency: 1 cycle from the handshake to out_valid.
//   - If can_load=1 and there is no grant: out_valid becomes 0 at the next edge.
//     Data registers may hold their old values. rr_ptr is unchanged.
//   - If out_valid=1 and out_ready=0: all out_* outputs are held bit-stable, no grant is issued,
//     and rr_ptr is unchanged.
//   - Simultaneous drain and load (out_valid=1, out_ready=1, grant): the new result replaces the
//     old one back-to-back. Throughput is 1 per cycle.
//   - Unpack, with f = field exponent and m = stored fraction:
//       f in 1..2^EXP_W-2 : out_exp = f-BIAS, out_frac = {1,m}
//       f == 0            : out_exp = 1-BIAS, out_frac = {0,m};
//                           out_zero = (m==0), out_denorm = (m!=0)
//       f == all-ones     : out_inf = (m==0), out_nan = (m!=0);
//                           out_exp = f-BIAS, out_frac = {1,m}
//     out_exp is computed at EXP_W+1 bits and cannot overflow.
//     At most one class flag is set at a time.
//   - Reset mid-operation: a pending result is discarded (out_valid=0 at the next edge) and
//     rr_ptr returns to 0. Requesters must re-present any word that was not handshaken.
//   - Fairness: while requester i keeps req_valid asserted and out_ready=1 every cycle,
//     it is granted within NREQ cycles.
// TESTING
//   1. req_valid[0]=1, word 0x07F000 (1.0), out_ready=1
//      -> next cycle out_valid=1, out_sign=0, out_exp=0, out_frac=0x1000, out_src=0.
//   2. word 0x180000 (-2.0)
//      -> out_sign=1, out_exp=+1, out_frac=0x1000.
//      word 0x000001
//      -> out_denorm=1, out_exp=-126 (9'h182), out_frac=0x0001.
//      word 0x000000
//      -> out_zero=1.
//      word 0x0FF000
//      -> out_inf=1.
//      word 0x0FF001
//      -> out_nan=1.
//   3. All 4 req_valid=1 continuously, out_ready=1
//      -> req_ready one-hot 1,2,4,8,1,...; out_src 0,1,2,3,0; no idle cycles.
//   4. out_valid=1, out_ready=0 for 3 cycles with all requesters valid
//      -> outputs stable and req_ready=0 throughout. After out_ready=1, the next grant is
//         rr_ptr's requester.
//   5. Only requester 2 valid, rr_ptr=3 -> grant 2, then rr_ptr=3. Wrap 3->0 is checked.
//   6. rst=1 for 1 cycle while out_valid=1 and rr_ptr=2
//      -> next cycle out_valid=0 and req_ready=0 during reset. The first grant after reset
//         goes to the lowest valid index.

Source files
------------

// File: rtl/fp21_unpack_arbiter.sv
// fp21_unpack_arbiter
//   Round-robin arbiter that shares one registered FP21 unpack stage among
//   NREQ requesters. The winning word is split into sign, unbiased exponent,
//   fraction with hidden bit, class flags and the source index. The result is
//   held in one output register with a valid/ready handshake.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_data  : per-requester word offer (word i at [i*W +: W])
//   req_ready           : one-hot (or zero) consume strobe, combinational
//   out_valid/out_ready : result handshake toward the arithmetic cores
//   out_sign/exp/frac   : unpacked fields (exp two's complement, frac has hidden bit)
//   out_src             : index of the requester that produced the result
//   out_zero/denorm/inf/nan : class flags, at most one set
module fp21_unpack_arbiter #(
  parameter int NREQ   = 4,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 12,
  parameter int BIAS   = 127,
  localparam int W     = 1 + EXP_W + FRAC_W,
  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXP_W:0]      out_exp,
  output logic [FRAC_W:0]     out_frac,
  output logic [SRC_W-1:0]    out_src,
  output logic                out_zero,
  output logic                out_denorm,
  output logic                out_inf,
  output logic                out_nan
);

  localparam logic [EXP_W:0]    BIAS_V    = (EXP_W+1)'(BIAS);
  localparam logic [EXP_W-1:0]  EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [SRC_W-1:0]  LAST_IDX  = SRC_W'(NREQ - 1);
  localparam logic [SRC_W:0]    NREQ_V    = (SRC_W+1)'(NREQ);

  typedef struct packed {
    logic              sign;
    logic [EXP_W:0]    exp;
    logic [FRAC_W:0]   frac;
    logic [SRC_W-1:0]  src;
    logic              zero;
    logic              denorm;
    logic              inf;
    logic              nan;
  } res_t;

  // Split one packed word into its unpacked fields and class flags.
  function automatic res_t unpack(input logic [W-1:0] word, input logic [SRC_W-1:0] src);
    res_t              r;
    logic [EXP_W-1:0]  f;
    logic [FRAC_W-1:0] m;
    f        = word[W-2:FRAC_W];
    m        = word[FRAC_W-1:0];
    r        = '0;
    r.sign   = word[W-1];
    r.src    = src;
    if (f == {EXP_W{1'b0}}) begin
      // Denormals and zero share the minimum normal exponent, no hidden bit.
      r.exp    = (EXP_W+1)'(1) - BIAS_V;
      r.frac   = {1'b0, m};
      r.zero   = (m == {FRAC_W{1'b0}});
      r.denorm = (m != {FRAC_W{1'b0}});
    end else if (f == EXP_ONES) begin
      r.exp    = {1'b0, f} - BIAS_V;
      r.frac   = {1'b1, m};
      r.inf    = (m == {FRAC_W{1'b0}});
      r.nan    = (m != {FRAC_W{1'b0}});
    end else begin
      r.exp    = {1'b0, f} - BIAS_V;
      r.frac   = {1'b1, m};
    end
    return r;
  endfunction

  res_t             res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             can_load_s;
  logic             grant_vld_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic [SRC_W:0]   sum_s;
  logic [SRC_W-1:0] cand_s;
  logic [W-1:0]     sel_word_s;

  // Round-robin search starting at rr_ptr; data never enters this path.
  always_comb begin
    can_load_s  = !out_valid_q || out_ready;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    sum_s       = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (sum_s >= NREQ_V) begin
        sum_s = sum_s - NREQ_V;
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[SRC_W-1:0];
      if (!grant_vld_s && req_valid[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (rst || !can_load_s) begin
      grant_vld_s = 1'b0;
    end else begin
      grant_vld_s = grant_vld_s;
    end
  end

  // One-hot consume strobe for the granted requester.
  always_comb begin
    if (grant_vld_s) begin
      req_ready = NREQ'(1'b1) << grant_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Mux the granted word using constant part-selects.
  always_comb begin
    sel_word_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == SRC_W'(i)) begin
        sel_word_s = req_data[i*W +: W];
      end else begin
        sel_word_s = sel_word_s;
      end
    end
  end

  // Next-state: load on grant, drain when free with no grant, otherwise hold.
  always_comb begin
    res_d       = res_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_vld_s) begin
      res_d       = unpack(sel_word_s, grant_idx_s);
      out_valid_d = 1'b1;
      if (grant_idx_s == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + SRC_W'(1);
      end
    end else if (can_load_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sign   = res_q.sign;
  assign out_exp    = res_q.exp;
  assign out_frac   = res_q.frac;
  assign out_src    = res_q.src;
  assign out_zero   = res_q.zero;
  assign out_denorm = res_q.denorm;
  assign out_inf    = res_q.inf;
  assign out_nan    = res_q.nan;

endmodule

// File: tb/tb_fp21_unpack_arbiter.sv
// tb_fp21_unpack_arbiter
//   Directed self-checking bench for fp21_unpack_arbiter (NREQ=4, FP21).
//   Inputs change #1 after the rising edge; outputs are sampled on the
//   falling edge.
module tb_fp21_unpack_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 21;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            out_valid;
  logic            out_ready;
  logic            out_sign;
  logic [8:0]      out_exp;
  logic [12:0]     out_frac;
  logic [1:0]      out_src;
  logic            out_zero;
  logic            out_denorm;
  logic            out_inf;
  logic            out_nan;

  int n_checks = 0;
  int n_fail   = 0;

  fp21_unpack_arbiter #(.NREQ(4), .EXP_W(8), .FRAC_W(12), .BIAS(127)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_frac   (out_frac),
    .out_src    (out_src),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_inf    (out_inf),
    .out_nan    (out_nan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] sign, input logic [31:0] exp,
                         input logic [31:0] frac, input logic [31:0] src, input logic [31:0] flags);
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_sign"},  32'(out_sign), sign);
    chk({tag, "_exp"},   32'(out_exp), exp);
    chk({tag, "_frac"},  32'(out_frac), frac);
    chk({tag, "_src"},   32'(out_src), src);
    chk({tag, "_flags"}, 32'({out_zero, out_denorm, out_inf, out_nan}), flags);
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_data[i*W +: W] = w;
  endtask

  // Offer one word on requester idx alone and leave the bench at the falling
  // edge after it has been loaded.
  task automatic load_one(input string tag, input int idx, input logic [W-1:0] w);
    @(posedge clk); #1;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    set_word(idx, w);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    out_ready = 1'b1;

    // Reset state: nothing granted, register cleared.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'({out_sign, out_exp, out_frac, out_src}), 32'h0);
    chk("rst_flags", 32'({out_zero, out_denorm, out_inf, out_nan}), 32'h0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;

    // Single words through requester 0: normal, negative, denormal, zero, inf, nan.
    load_one("one",  0, 21'h07F000);
    chk_res("one",  32'h0, 32'h000, 32'h1000, 32'h0, 32'h0);
    load_one("m2",   0, 21'h180000);
    chk_res("m2",   32'h1, 32'h001, 32'h1000, 32'h0, 32'h0);
    load_one("den",  0, 21'h000001);
    chk_res("den",  32'h0, 32'h182, 32'h0001, 32'h0, 32'h4);
    load_one("zero", 0, 21'h000000);
    chk_res("zero", 32'h0, 32'h182, 32'h0000, 32'h0, 32'h8);
    load_one("inf",  0, 21'h0FF000);
    chk_res("inf",  32'h0, 32'h080, 32'h1000, 32'h0, 32'h2);
    load_one("nan",  0, 21'h0FF001);
    chk_res("nan",  32'h0, 32'h080, 32'h1001, 32'h0, 32'h1);
    // Drained with nothing offered.
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'h0);

    // Park the pointer at 0 by granting requester 3.
    load_one("r3", 3, 21'h07F003);
    chk_res("r3", 32'h0, 32'h000, 32'h1003, 32'h3, 32'h0);

    // All requesters valid, back-to-back round robin.
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_word(i, 21'h07F000 | 21'(i));
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 1) begin
        chk("rr_valid", 32'(out_valid), 32'h1);
        chk("rr_src",   32'(out_src), 32'((k - 1) % 4));
        chk("rr_frac",  32'(out_frac), 32'(13'h1000 | 13'((k - 1) % 4)));
      end
      @(posedge clk); #1;
    end
    // Grant from requester 1 now held; pointer at 2.

    // Backpressure: hold outputs, no grant.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk_res("bp", 32'h0, 32'h000, 32'h1001, 32'h1, 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    @(negedge clk);
    chk_res("bp_resume", 32'h0, 32'h000, 32'h1002, 32'h2, 32'h0);

    // Pointer at 3 with only requester 2 valid, then wrap 3 -> 0.
    req_valid = 4'b0100;
    #1;
    chk("wrap_r2_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("wrap_r2_src", 32'(out_src), 32'h2);
    chk("wrap_r3_ready", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_r3_src", 32'(out_src), 32'h3);
    chk("wrap_r0_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("wrap_r0_src", 32'(out_src), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Pointer at 1: grant 1, pointer moves to 2, then reset mid-operation.
    req_valid = 4'hF;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst_ready", 32'(req_ready), 32'h0);
    chk("in_rst_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk_res("post_rst", 32'h0, 32'h000, 32'h1001, 32'h1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
